// File: rtl/cam_lvds_align_ctrl.sv
// -----------------------------------------------------------------------------
// cam_lvds_align_ctrl
//
// Per-camera word-alignment sequencer for a deserialized LVDS receiver.
// Lanes are trained one at a time. The selected lane's parallel word is
// compared with the sensor training word. Single-cycle bitslip pulses are
// issued until STABLE consecutive matching words are seen on that lane. The
// sequencer then moves to the next lane. When the last lane is aligned it
// parks in DONE.
//
// One instance serves one camera. It is clocked by that camera's
// rx_coreclock and sits between the cam_lvds_rx instance and the PIO
// control/status bits.
//
// Optional feature (compile-time macro CAM_ALIGN_RELOCK_EN):
//   When the macro is defined, the sync lane (LANES-1) is monitored while the
//   sequencer is in DONE. Four consecutive mismatching words drop
//   aligned/lane_ok and restart alignment from WAIT_LOCK. No start pulse is
//   needed. When the macro is undefined, DONE ignores rxd.
//
// Ports
//   c          in   clock (camera rx_coreclock)
//   rst        in   asynchronous reset, active-high
//   start      in   single-cycle pulse: begin/restart alignment
//   rx_locked  in   receiver PLL lock
//   rxd        in   LANES*W deserialized words, lane i = rxd[i*W +: W]
//   bitslip    out  one-hot single-cycle bitslip pulse per lane
//   lane_ok    out  per-lane aligned flags
//   aligned    out  all lanes aligned (DONE)
//   error      out  a lane ran out of slips (FAIL)
//   busy       out  sequencer active (WAIT_LOCK, CHECK, SLIP, SETTLE)
// -----------------------------------------------------------------------------
module cam_lvds_align_ctrl #(
  parameter int             LANES    = 5,
  parameter int             W        = 8,
  parameter logic [W-1:0]   TRAIN    = 8'h3A,
  parameter int             SETTLE   = 4,
  parameter int             STABLE   = 16,
  parameter int             MAX_SLIP = 16
) (
  input  logic               c,
  input  logic               rst,
  input  logic               start,
  input  logic               rx_locked,
  input  logic [LANES*W-1:0] rxd,
  output logic [LANES-1:0]   bitslip,
  output logic [LANES-1:0]   lane_ok,
  output logic               aligned,
  output logic               error,
  output logic               busy
);

  localparam int IW = (LANES > 1)  ? $clog2(LANES)  : 1;
  localparam int MW = $clog2(STABLE + 1);
  localparam int SW = $clog2(MAX_SLIP + 1);
  localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IW-1:0] LAST_LANE   = IW'(LANES - 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(STABLE - 1);
  localparam logic [SW-1:0] SLIP_MAX    = SW'(MAX_SLIP);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOCK,
    S_CHECK,
    S_SLIP,
    S_SETTLE,
    S_DONE,
    S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;        // lane currently being trained
  logic [MW-1:0]   match_q, match_d;    // consecutive matching words
  logic [SW-1:0]   slip_q, slip_d;      // slips spent on the current lane
  logic [TW-1:0]   settle_q, settle_d;  // cycles spent in SETTLE

  logic [LANES-1:0] bitslip_d, lane_ok_d;
  logic             aligned_d, error_d, busy_d;

  logic [W-1:0] lane_word;
  logic         lane_match;

  assign lane_word  = rxd[int'(idx_q) * W +: W];
  assign lane_match = (lane_word == TRAIN);

`ifdef CAM_ALIGN_RELOCK_EN
  logic [1:0]   bad_q, bad_d;           // consecutive bad sync words in DONE
  logic [W-1:0] sync_word;

  assign sync_word = rxd[(LANES-1)*W +: W];
`endif

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational blocks.
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      match_q  <= '0;
      slip_q   <= '0;
      settle_q <= '0;
      bitslip  <= '0;
      lane_ok  <= '0;
      aligned  <= 1'b0;
      error    <= 1'b0;
      busy     <= 1'b0;
`ifdef CAM_ALIGN_RELOCK_EN
      bad_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      match_q  <= match_d;
      slip_q   <= slip_d;
      settle_q <= settle_d;
      bitslip  <= bitslip_d;
      lane_ok  <= lane_ok_d;
      aligned  <= aligned_d;
      error    <= error_d;
      busy     <= busy_d;
`ifdef CAM_ALIGN_RELOCK_EN
      bad_q    <= bad_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the case statement. Without a
  // default, a path that skips an assignment would infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    match_d   = match_q;
    slip_d    = slip_q;
    settle_d  = settle_q;
    lane_ok_d = lane_ok;
`ifdef CAM_ALIGN_RELOCK_EN
    bad_d     = '0;
`endif

    case (state_q)
      S_IDLE, S_FAIL: begin
        // FAIL holds the partial lane_ok until a restart, whatever the PLL does.
        if (start) begin
          state_d   = S_WAIT_LOCK;
          lane_ok_d = '0;
          idx_d     = '0;
        end
      end

      S_WAIT_LOCK: begin
        if (rx_locked) begin
          state_d = S_CHECK;
          match_d = '0;
          slip_d  = '0;
        end
      end

      S_CHECK: begin
        if (lane_match) begin
          if (match_q == MATCH_LAST) begin
            lane_ok_d[idx_q] = 1'b1;
            if (idx_q == LAST_LANE) begin
              state_d = S_DONE;
              match_d = MW'(STABLE);
            end else begin
              idx_d   = idx_q + 1'b1;
              match_d = '0;
              slip_d  = '0;
            end
          end else begin
            match_d = match_q + 1'b1;
          end
        end else begin
          match_d = '0;
          state_d = (slip_q == SLIP_MAX) ? S_FAIL : S_SLIP;
        end
      end

      S_SLIP: begin
        if (slip_q != SLIP_MAX) slip_d = slip_q + 1'b1;
        settle_d = '0;
        state_d  = S_SETTLE;
      end

      S_SETTLE: begin
        // Words still in flight from before the slip are ignored; matching
        // restarts from zero once the receiver has settled.
        if (settle_q == SETTLE_LAST) begin
          state_d = S_CHECK;
          match_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      S_DONE: begin
`ifdef CAM_ALIGN_RELOCK_EN
        if (sync_word != TRAIN) begin
          if (bad_q == 2'd3) begin
            state_d   = S_WAIT_LOCK;
            lane_ok_d = '0;
            idx_d     = '0;
          end else begin
            bad_d = bad_q + 2'd1;
          end
        end
`endif
        if (start) begin
          state_d   = S_WAIT_LOCK;
          lane_ok_d = '0;
          idx_d     = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Lock loss overrides everything else, including a simultaneous start.
    // Redirecting to WAIT_LOCK also suppresses a SLIP that CHECK would
    // otherwise have scheduled.
    if (!rx_locked &&
        (state_q inside {S_CHECK, S_SLIP, S_SETTLE, S_DONE})) begin
      state_d   = S_WAIT_LOCK;
      lane_ok_d = '0;
      idx_d     = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: decoded from the next state so the flops carry the outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    bitslip_d = '0;
    if (state_d == S_SLIP) bitslip_d[idx_d] = 1'b1;
    aligned_d = (state_d == S_DONE);
    error_d   = (state_d == S_FAIL);
    busy_d    = (state_d inside {S_WAIT_LOCK, S_CHECK, S_SLIP, S_SETTLE});
  end

endmodule

// File: tb/tb_cam_lvds_align_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cam_lvds_align_ctrl
//
// Directed bench for cam_lvds_align_ctrl.
//
// The receiver model emits the training word rotated by a per-lane offset.
// Each bitslip pulse on a lane removes one bit of offset from that lane. The
// bench can kill a lane so it never carries the training word. It can also
// corrupt individual words on any lane.
// -----------------------------------------------------------------------------
module tb_cam_lvds_align_ctrl;

  localparam int         LANES  = 5;
  localparam int         W      = 8;
  localparam int         SETTLE = 4;
  localparam logic [7:0] TRAIN  = 8'h3A;
  localparam int         BUDGET = 3000;

  logic               c = 1'b0;
  logic               rst;
  logic               start;
  logic               rx_locked;
  logic [LANES*W-1:0] rxd;
  logic [LANES-1:0]   bitslip;
  logic [LANES-1:0]   lane_ok;
  logic               aligned;
  logic               error;
  logic               busy;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  int               slips [LANES] = '{default: 0};
  int               base  [LANES];
  logic [2:0]       dly   [LANES];
  logic [LANES-1:0] kill;
  logic [LANES-1:0] corrupt;

  always #5 c = ~c;

  cam_lvds_align_ctrl dut (
    .c         (c),
    .rst       (rst),
    .start     (start),
    .rx_locked (rx_locked),
    .rxd       (rxd),
    .bitslip   (bitslip),
    .lane_ok   (lane_ok),
    .aligned   (aligned),
    .error     (error),
    .busy      (busy)
  );

  // ---------------------------------------------------------------------------
  // Receiver model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] rotl(input logic [7:0] w, input logic [2:0] k);
    logic [15:0] d;
    d = {w, w} << k;
    return d[15:8];
  endfunction

  always_comb begin
    rxd = '0;
    for (int i = 0; i < LANES; i++) begin
      if (kill[i])         rxd[i*W +: W] = 8'h00;
      else if (corrupt[i]) rxd[i*W +: W] = 8'hC5;
      else                 rxd[i*W +: W] = rotl(TRAIN, dly[i] - 3'(slips[i]));
    end
  end

  always @(posedge c) begin
    for (int i = 0; i < LANES; i++)
      if (bitslip[i]) slips[i] <= slips[i] + 1;
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offsets are relative to the slips the model has already absorbed.
  task automatic set_delays(input int d0, input int d1, input int d2, input int d3, input int d4);
    int d [LANES];
    d = '{d0, d1, d2, d3, d4};
    for (int i = 0; i < LANES; i++) dly[i] = 3'(d[i] + slips[i]);
  endtask

  task automatic snap();
    for (int i = 0; i < LANES; i++) base[i] = slips[i];
  endtask

  task automatic check_slips(input string tag, input int e0, input int e1, input int e2,
                             input int e3, input int e4);
    int e [LANES];
    e = '{e0, e1, e2, e3, e4};
    for (int i = 0; i < LANES; i++)
      check($sformatf("%s_lane%0d", tag, i), 32'(slips[i] - base[i]), 32'(e[i]));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge c);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(aligned || error) && n < BUDGET) begin
      @(negedge c);
      n++;
    end
    check(tag, 32'(aligned || error), 32'd1);
  endtask

  task automatic wait_slip(input int lane, input string tag);
    int n = 0;
    while (bitslip[lane] !== 1'b1 && n < BUDGET) begin
      @(negedge c);
      n++;
    end
    check(tag, 32'(bitslip[lane]), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Per-cycle bitslip monitor
  // ---------------------------------------------------------------------------
  logic [LANES-1:0] prev_bs = '0;
  int               gap     = 1000;

  always @(negedge c) begin
    if (rst) begin
      prev_bs <= '0;
      gap     <= 1000;
    end else begin
      check("bitslip_onehot0", 32'($onehot0(bitslip)), 32'd1);
      if (prev_bs != '0) check("bitslip_one_cycle", 32'(bitslip), 32'd0);
      if (bitslip != '0) check("bitslip_gap", 32'(gap >= SETTLE), 32'd1);
      prev_bs <= bitslip;
      gap     <= (bitslip != '0) ? 0 : gap + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    rx_locked = 1'b0;
    kill      = '0;
    corrupt   = '0;
    set_delays(0, 0, 0, 0, 0);
    repeat (3) @(negedge c);

    check("rst_bitslip", 32'(bitslip), 32'd0);
    check("rst_lane_ok", 32'(lane_ok), 32'd0);
    check("rst_aligned", 32'(aligned), 32'd0);
    check("rst_error",   32'(error),   32'd0);
    check("rst_busy",    32'(busy),    32'd0);

    rst = 1'b0;
    @(negedge c);
    check("idle_busy", 32'(busy), 32'd0);

    // Start with the PLL unlocked: the sequencer waits in WAIT_LOCK.
    set_delays(0, 3, 7, 1, 5);
    snap();
    pulse_start();
    repeat (5) @(negedge c);
    check("wlock_busy",    32'(busy),    32'd1);
    check("wlock_bitslip", 32'(bitslip), 32'd0);
    check("wlock_lane_ok", 32'(lane_ok), 32'd0);

    // 1: lanes delayed by 0,3,7,1,5 bits.
    rx_locked = 1'b1;
    wait_done("t1_done");
    check("t1_aligned", 32'(aligned), 32'd1);
    check("t1_lane_ok", 32'(lane_ok), 32'h1F);
    check("t1_error",   32'(error),   32'd0);
    check("t1_busy",    32'(busy),    32'd0);
    check_slips("t1_slips", 0, 3, 7, 1, 5);

    // 2: lane 2 never carries the training word.
    kill = 5'b00100;
    set_delays(0, 0, 0, 0, 0);
    snap();
    pulse_start();
    wait_done("t2_done");
    check("t2_error",   32'(error),   32'd1);
    check("t2_aligned", 32'(aligned), 32'd0);
    check("t2_lane_ok", 32'(lane_ok), 32'h03);
    check("t2_busy",    32'(busy),    32'd0);
    check_slips("t2_slips", 0, 0, 16, 0, 0);
    // FAIL ignores the PLL.
    rx_locked = 1'b0;
    repeat (2) @(negedge c);
    rx_locked = 1'b1;
    @(negedge c);
    check("t2_fail_hold_err", 32'(error),   32'd1);
    check("t2_fail_hold_ok",  32'(lane_ok), 32'h03);
    kill = '0;

    // 3: lock loss for one cycle while lane 3 settles.
    set_delays(0, 0, 0, 1, 0);
    snap();
    pulse_start();
    wait_slip(3, "t3_slip3");
    check("t3_pre_lane_ok", 32'(lane_ok), 32'h07);
    @(negedge c);
    rx_locked = 1'b0;
    @(negedge c);
    check("t3_ll_lane_ok", 32'(lane_ok), 32'd0);
    check("t3_ll_aligned", 32'(aligned), 32'd0);
    check("t3_ll_busy",    32'(busy),    32'd1);
    check("t3_ll_bitslip", 32'(bitslip), 32'd0);
    rx_locked = 1'b1;
    wait_done("t3_done");
    check("t3_aligned", 32'(aligned), 32'd1);
    check("t3_lane_ok", 32'(lane_ok), 32'h1F);
    check_slips("t3_slips", 0, 0, 0, 1, 0);

    // 4: start in DONE restarts; start while busy is ignored.
    set_delays(0, 2, 0, 0, 0);
    snap();
    pulse_start();
    check("t4_restart_lane_ok", 32'(lane_ok), 32'd0);
    check("t4_restart_aligned", 32'(aligned), 32'd0);
    check("t4_restart_busy",    32'(busy),    32'd1);
    wait_slip(1, "t4_slip1");
    pulse_start();
    check("t4_busy_start_ok",   32'(lane_ok), 32'h01);
    check("t4_busy_start_busy", 32'(busy),    32'd1);
    wait_done("t4_done");
    check("t4_aligned", 32'(aligned), 32'd1);
    check("t4_lane_ok", 32'(lane_ok), 32'h1F);
    check_slips("t4_slips", 0, 2, 0, 0, 0);

    // 5: one corrupted word in the 16th check cycle of lane 0 (match count 15).
    set_delays(0, 0, 0, 0, 0);
    snap();
    pulse_start();
    repeat (16) @(negedge c);
    check("t5_pre_lane_ok", 32'(lane_ok), 32'd0);
    corrupt = 5'b00001;
    @(negedge c);
    corrupt = '0;
    check("t5_slip",    32'(bitslip), 32'h01);
    check("t5_lane_ok", 32'(lane_ok), 32'd0);
    wait_done("t5_done");
    check("t5_aligned",  32'(aligned), 32'd1);
    check("t5_lane_ok2", 32'(lane_ok), 32'h1F);
    check_slips("t5_slips", 8, 0, 0, 0, 0);

    // 6: bad sync-lane words while in DONE.
    corrupt = 5'b10000;
    repeat (3) @(negedge c);
    corrupt = '0;
    @(negedge c);
    check("t6_3bad_aligned", 32'(aligned), 32'd1);
    check("t6_3bad_lane_ok", 32'(lane_ok), 32'h1F);
    corrupt = 5'b10000;
`ifdef CAM_ALIGN_RELOCK_EN
    repeat (4) @(negedge c);
    corrupt = '0;
    check("t6_4bad_aligned", 32'(aligned), 32'd0);
    check("t6_4bad_lane_ok", 32'(lane_ok), 32'd0);
    check("t6_4bad_busy",    32'(busy),    32'd1);
    wait_done("t6_done");
    check("t6_realigned", 32'(aligned), 32'd1);
    check("t6_relane_ok", 32'(lane_ok), 32'h1F);
`else
    repeat (8) @(negedge c);
    corrupt = '0;
    check("t6_hold_aligned", 32'(aligned), 32'd1);
    check("t6_hold_lane_ok", 32'(lane_ok), 32'h1F);
    check("t6_hold_busy",    32'(busy),    32'd0);
`endif

    // 7: reset asserted while a bitslip pulse is on the port.
    set_delays(1, 0, 0, 0, 0);
    snap();
    pulse_start();
    wait_slip(0, "t7_slip0");
    rst = 1'b1;
    #1;
    check("t7_rst_bitslip", 32'(bitslip), 32'd0);
    check("t7_rst_lane_ok", 32'(lane_ok), 32'd0);
    check("t7_rst_aligned", 32'(aligned), 32'd0);
    check("t7_rst_error",   32'(error),   32'd0);
    check("t7_rst_busy",    32'(busy),    32'd0);
    @(negedge c);
    rst = 1'b0;
    @(negedge c);
    check("t7_idle_busy",    32'(busy),    32'd0);
    check("t7_idle_bitslip", 32'(bitslip), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
